// File: rtl/playseq_condiciona_entradas_pkg.sv
// playseq_condiciona_entradas_pkg: shared FSM states, default debounce window and one-hot helper
package playseq_condiciona_entradas_pkg;

    // 20 ms at the 1 kHz game clock
    localparam int DEBOUNCE_CICLOS_DEFAULT = 20;

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        EMITE         = 2'd1,
        ESPERA_SOLTAR = 2'd2,
        INVALIDA      = 2'd3
    } estado_t;

    // True when exactly one bit is set
    function automatic logic is_one_hot(input logic [3:0] b);
        return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/playseq_condiciona_entradas_if.sv
// playseq_condiciona_entradas_if: raw button inputs and conditioned event outputs
interface playseq_condiciona_entradas_if;

    logic [3:0] i_botoes_raw;
    logic       i_jogar_raw;
    logic [3:0] o_botoes;
    logic       o_jogada_pulso;
    logic [3:0] o_jogada_valor;
    logic       o_jogar_pulso;
    logic       o_multiplas;
    logic [1:0] o_db_estado;

    // Conditioning block side
    modport slave (
        input  i_botoes_raw, i_jogar_raw,
        output o_botoes, o_jogada_pulso, o_jogada_valor, o_jogar_pulso, o_multiplas, o_db_estado
    );

    // Board / game core side
    modport master (
        output i_botoes_raw, i_jogar_raw,
        input  o_botoes, o_jogada_pulso, o_jogada_valor, o_jogar_pulso, o_multiplas, o_db_estado
    );

endinterface

// File: rtl/playseq_condiciona_entradas_debounce_bit.sv
// debounce_bit: two-flop synchroniser followed by a consecutive-mismatch debounce counter
module debounce_bit
    import playseq_condiciona_entradas_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_stable
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_stable;

    // Stable value only flips after DEBOUNCE_CICLOS consecutive clocks of disagreement
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync   <= 2'b00;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/playseq_condiciona_entradas.sv
// playseq_condiciona_entradas: debounces the board buttons and emits single-cycle play/start events
module playseq_condiciona_entradas
    import playseq_condiciona_entradas_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_DEFAULT
) (
    input logic                            clock,
    input logic                            reset,
    playseq_condiciona_entradas_if.slave   bus
);

    logic [4:0] w_raw;
    logic [4:0] w_stable;
    logic [3:0] w_b;
    logic       w_jogar;

    estado_t    r_estado;
    logic       r_jogada_pulso;
    logic [3:0] r_jogada_valor;
    logic       r_multiplas;
    logic       r_jogar_d;
    logic       r_jogar_pulso;

    // Bit 4 carries jogar, bits 3:0 the play buttons
    assign w_raw   = {bus.i_jogar_raw, bus.i_botoes_raw};
    assign w_b     = w_stable[3:0];
    assign w_jogar = w_stable[4];

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : g_db
            debounce_bit #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_db (
                .clock    (clock),
                .reset    (reset),
                .i_raw    (w_raw[g]),
                .o_stable (w_stable[g])
            );
        end
    endgenerate

    // Rising-edge detector on debounced jogar, independent of the play FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_jogar_d     <= 1'b0;
            r_jogar_pulso <= 1'b0;
        end else begin
            r_jogar_d     <= w_jogar;
            r_jogar_pulso <= w_jogar & ~r_jogar_d;
        end
    end

    // Play FSM with registered Moore outputs; outputs are set on entry to the state that owns them
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado       <= OCIOSO;
            r_jogada_pulso <= 1'b0;
            r_jogada_valor <= 4'd0;
            r_multiplas    <= 1'b0;
        end else begin
            r_jogada_pulso <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (is_one_hot(w_b)) begin
                        r_estado       <= EMITE;
                        r_jogada_pulso <= 1'b1;
                        r_jogada_valor <= w_b;
                    end else if (w_b != 4'd0) begin
                        r_estado    <= INVALIDA;
                        r_multiplas <= 1'b1;
                    end
                end
                EMITE: begin
                    r_estado <= ESPERA_SOLTAR;
                end
                ESPERA_SOLTAR: begin
                    if (w_b == 4'd0) r_estado <= OCIOSO;
                end
                INVALIDA: begin
                    if (w_b == 4'd0) begin
                        r_estado    <= OCIOSO;
                        r_multiplas <= 1'b0;
                    end
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign bus.o_botoes       = w_b;
    assign bus.o_jogada_pulso = r_jogada_pulso;
    assign bus.o_jogada_valor = r_jogada_valor;
    assign bus.o_jogar_pulso  = r_jogar_pulso;
    assign bus.o_multiplas    = r_multiplas;
    assign bus.o_db_estado    = r_estado;

endmodule

// File: tb/tb_playseq_condiciona_entradas.sv
// tb_playseq_condiciona_entradas: directed self-checking bench with DEBOUNCE_CICLOS=4 (event latency 7 clocks)
module tb_playseq_condiciona_entradas;

    logic clock;
    logic reset;
    int   n_chk;
    int   n_fail;
    int   jp_cnt;
    int   gp_cnt;

    playseq_condiciona_entradas_if bus();

    playseq_condiciona_entradas #(.DEBOUNCE_CICLOS(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n clocks, sampling 1 time unit after each rising edge and counting pulses
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (bus.o_jogada_pulso === 1'b1) jp_cnt++;
            if (bus.o_jogar_pulso === 1'b1) gp_cnt++;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        jp_cnt = 0;
        gp_cnt = 0;
        reset  = 1'b1;
        bus.i_botoes_raw = 4'd0;
        bus.i_jogar_raw  = 1'b0;

        // 1 reset values, then release with inputs idle
        tick(2);
        chk("rst_botoes", 8'(bus.o_botoes), 8'h0);
        chk("rst_estado", 8'(bus.o_db_estado), 8'h0);
        chk("rst_valor", 8'(bus.o_jogada_valor), 8'h0);
        chk("rst_mult", 8'(bus.o_multiplas), 8'h0);
        chk("rst_pulses", 8'({bus.o_jogada_pulso, bus.o_jogar_pulso}), 8'h0);
        reset = 1'b0;
        tick(10);
        chk("idle_no_play", 8'(jp_cnt), 8'd0);
        chk("idle_no_jogar", 8'(gp_cnt), 8'd0);

        // 2 clean press: pulse exactly 7 clocks after the raw edge, no repeat while held
        jp_cnt = 0;
        bus.i_botoes_raw = 4'b0100;
        tick(6);
        chk("clean_pre", 8'(bus.o_jogada_pulso), 8'h0);
        tick(1);
        chk("clean_pulse", 8'(bus.o_jogada_pulso), 8'h1);
        chk("clean_valor", 8'(bus.o_jogada_valor), 8'h4);
        chk("clean_emite", 8'(bus.o_db_estado), 8'h1);
        tick(13);
        chk("clean_once", 8'(jp_cnt), 8'd1);
        chk("clean_espera", 8'(bus.o_db_estado), 8'h2);
        chk("clean_botoes", 8'(bus.o_botoes), 8'h4);

        // reset mid-operation clears asynchronously; held button accepted once after release
        reset = 1'b1;
        #1;
        chk("arst_estado", 8'(bus.o_db_estado), 8'h0);
        chk("arst_botoes", 8'(bus.o_botoes), 8'h0);
        chk("arst_valor", 8'(bus.o_jogada_valor), 8'h0);
        tick(2);
        reset  = 1'b0;
        jp_cnt = 0;
        tick(6);
        chk("held_pre", 8'(bus.o_jogada_pulso), 8'h0);
        tick(1);
        chk("held_pulse", 8'(bus.o_jogada_pulso), 8'h1);
        chk("held_valor", 8'(bus.o_jogada_valor), 8'h4);
        tick(5);
        chk("held_once", 8'(jp_cnt), 8'd1);
        bus.i_botoes_raw = 4'b0000;
        tick(8);
        chk("release_ocioso", 8'(bus.o_db_estado), 8'h0);
        chk("release_botoes", 8'(bus.o_botoes), 8'h0);

        // 3 bounce: 2-clock toggles are filtered, one pulse 7 clocks after the final edge
        jp_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            bus.i_botoes_raw = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            tick(2);
        end
        bus.i_botoes_raw = 4'b0001;
        tick(6);
        chk("bounce_none", 8'(jp_cnt), 8'd0);
        tick(1);
        chk("bounce_pulse", 8'(bus.o_jogada_pulso), 8'h1);
        chk("bounce_valor", 8'(bus.o_jogada_valor), 8'h1);
        tick(10);
        chk("bounce_once", 8'(jp_cnt), 8'd1);
        bus.i_botoes_raw = 4'b0000;
        tick(8);

        // 4 simultaneous buttons -> INVALIDA, no play event, value kept
        jp_cnt = 0;
        bus.i_botoes_raw = 4'b0011;
        tick(7);
        chk("multi_flag", 8'(bus.o_multiplas), 8'h1);
        chk("multi_estado", 8'(bus.o_db_estado), 8'h3);
        tick(5);
        chk("multi_no_pulse", 8'(jp_cnt), 8'd0);
        chk("multi_valor", 8'(bus.o_jogada_valor), 8'h1);
        bus.i_botoes_raw = 4'b0000;
        tick(8);
        chk("multi_clear", 8'(bus.o_multiplas), 8'h0);
        chk("multi_ocioso", 8'(bus.o_db_estado), 8'h0);

        // 5 staggered press: first accepted, late extra button ignored
        jp_cnt = 0;
        bus.i_botoes_raw = 4'b0001;
        tick(10);
        bus.i_botoes_raw = 4'b1001;
        tick(10);
        chk("stag_once", 8'(jp_cnt), 8'd1);
        chk("stag_valor", 8'(bus.o_jogada_valor), 8'h1);
        chk("stag_espera", 8'(bus.o_db_estado), 8'h2);
        bus.i_botoes_raw = 4'b0000;
        tick(8);
        jp_cnt = 0;
        bus.i_botoes_raw = 4'b1000;
        tick(7);
        chk("stag2_pulse", 8'(bus.o_jogada_pulso), 8'h1);
        chk("stag2_valor", 8'(bus.o_jogada_valor), 8'h8);
        bus.i_botoes_raw = 4'b0000;
        tick(8);

        // 6 jogar: 3-clock glitch filtered, held press gives one pulse at clock 7
        gp_cnt = 0;
        bus.i_jogar_raw = 1'b1;
        tick(3);
        bus.i_jogar_raw = 1'b0;
        tick(8);
        chk("jogar_glitch", 8'(gp_cnt), 8'd0);
        bus.i_jogar_raw = 1'b1;
        tick(6);
        chk("jogar_pre", 8'(bus.o_jogar_pulso), 8'h0);
        tick(1);
        chk("jogar_pulse", 8'(bus.o_jogar_pulso), 8'h1);
        tick(3);
        chk("jogar_once", 8'(gp_cnt), 8'd1);
        bus.i_jogar_raw = 1'b0;
        tick(8);

        // jogar and play press together: both pulses in the same clock
        bus.i_jogar_raw  = 1'b1;
        bus.i_botoes_raw = 4'b0100;
        tick(7);
        chk("both_jogar", 8'(bus.o_jogar_pulso), 8'h1);
        chk("both_jogada", 8'(bus.o_jogada_pulso), 8'h1);
        bus.i_jogar_raw  = 1'b0;
        bus.i_botoes_raw = 4'b0000;
        tick(8);
        chk("end_ocioso", 8'(bus.o_db_estado), 8'h0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
